multicycle_rf_dm_alu: RTL

- Parametrised successor to the single-cycle register-file / data-memory / ALU datapath.
- Executes one command at a time (R-type, ADDI, LW, SW) through an internal multicycle FSM instead of externally driven mux and write-enable controls.
- Accepts commands over a valid/ready handshake and pulses `done` on completion.
- Sits between the future instruction decoder and the shared register/memory resources.

---
 rtl/multicycle_rf_dm_alu.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_rf_dm_alu.sv
// Multicycle datapath: register file, data memory and ALU sequenced by an internal FSM.
// Commands arrive over a valid/ready handshake; completion is signalled by a one-cycle done pulse.
module multicycle_rf_dm_alu #(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5,
    parameter int DM_AW  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [RF_AW-1:0]  rs,
    input  logic [RF_AW-1:0]  rt,
    input  logic [RF_AW-1:0]  rd,
    input  logic [15:0]       imm,
    input  logic [5:0]        funct,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero,
    output logic              ovf,
    output logic              done,
    input  logic [RF_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int RF_DEPTH = 1 << RF_AW;
    localparam int DM_DEPTH = 1 << DM_AW;
    localparam int MSB      = DATA_W - 1;

    localparam logic [1:0] OP_R    = 2'b00;
    localparam logic [1:0] OP_LW   = 2'b01;
    localparam logic [1:0] OP_SW   = 2'b10;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_op;
    logic [RF_AW-1:0]    r_rs, r_rt, r_rd;
    logic [15:0]         r_imm;
    logic [5:0]          r_funct;
    logic [DATA_W-1:0]   r_a, r_b, r_alu, r_mdr;
    logic                r_zero, r_ovf, r_done;
    logic [DATA_W-1:0]   r_rf [RF_DEPTH];
    logic [DATA_W-1:0]   r_dm [DM_DEPTH];

    logic                w_accept;
    logic [DATA_W-1:0]   w_rfA, w_rfB, w_sext, w_opB, w_sum, w_diff, w_aluRes;
    logic                w_aluOvf, w_slt;
    logic                w_rfWe, w_dmWe, w_doneSet;
    logic [RF_AW-1:0]    w_rfWaddr;
    logic [DATA_W-1:0]   w_rfWdata;
    logic [DM_AW-1:0]    w_dmAddr;

    // A done cycle is still IDLE but not yet ready, so the next accept lands one cycle later.
    assign cmd_ready = (r_state == S_IDLE) && !r_done;
    assign w_accept  = cmd_valid && cmd_ready;

    assign w_rfA    = (r_rs == '0) ? '0 : r_rf[r_rs];
    assign w_rfB    = (r_rt == '0) ? '0 : r_rf[r_rt];
    assign dbg_data = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

    assign w_sext   = {{(DATA_W-16){r_imm[15]}}, r_imm};
    assign w_opB    = (r_op == OP_R) ? r_b : w_sext;
    assign w_sum    = r_a + w_opB;
    assign w_diff   = r_a - r_b;
    assign w_slt    = $signed(r_a) < $signed(r_b);
    assign w_dmAddr = r_alu[DM_AW-1:0];

    assign alu_out = r_alu;
    assign zero    = r_zero;
    assign ovf     = r_ovf;
    assign done    = r_done;

    always_comb begin
        w_aluRes = '0;
        w_aluOvf = 1'b0;
        if (r_op != OP_R) begin
            w_aluRes = w_sum;
        end else begin
            case (r_funct)
                F_ADD: begin
                    w_aluRes = w_sum;
                    w_aluOvf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
                end
                F_SUB: begin
                    w_aluRes = w_diff;
                    w_aluOvf = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
                end
                F_AND:   w_aluRes = r_a & r_b;
                F_OR:    w_aluRes = r_a | r_b;
                F_XOR:   w_aluRes = r_a ^ r_b;
                F_NOR:   w_aluRes = ~(r_a | r_b);
                F_SLT:   w_aluRes = {{(DATA_W-1){1'b0}}, w_slt};
                default: w_aluRes = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_rfWe    = 1'b0;
        w_rfWaddr = r_rt;
        w_rfWdata = r_alu;
        w_dmWe    = 1'b0;
        w_doneSet = 1'b0;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = (r_op == OP_LW || r_op == OP_SW) ? S_MEM : S_WB;
            S_MEM: begin
                if (r_op == OP_SW) begin
                    w_dmWe    = 1'b1;
                    w_doneSet = 1'b1;
                    w_next    = S_IDLE;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                w_rfWe    = 1'b1;
                w_doneSet = 1'b1;
                w_next    = S_IDLE;
                if (r_op == OP_R)  w_rfWaddr = r_rd;
                if (r_op == OP_LW) w_rfWdata = r_mdr;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // Reset clears the whole datapath and both memories, overriding any write in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_imm   <= '0;
            r_funct <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_alu   <= '0;
            r_mdr   <= '0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
            for (int j = 0; j < DM_DEPTH; j++) r_dm[j] <= '0;
        end else begin
            r_done <= w_doneSet;
            if (w_accept) begin
                r_op    <= cmd_op;
                r_rs    <= rs;
                r_rt    <= rt;
                r_rd    <= rd;
                r_imm   <= imm;
                r_funct <= funct;
            end
            if (r_state == S_DECODE) begin
                r_a <= w_rfA;
                r_b <= w_rfB;
            end
            if (r_state == S_EXEC) begin
                r_alu  <= w_aluRes;
                r_zero <= (w_aluRes == '0);
                r_ovf  <= w_aluOvf;
            end
            if (r_state == S_MEM && r_op == OP_LW) r_mdr <= r_dm[w_dmAddr];
            if (w_dmWe) r_dm[w_dmAddr] <= r_b;
            if (w_rfWe && w_rfWaddr != '0) r_rf[w_rfWaddr] <= w_rfWdata;
        end
    end

endmodule
